// File: rtl/xm23_pkg.sv
// xm23 shared definitions for the interrupt controller.
// State encoding, pic_out layout and default vector base.
package xm23_pkg;

  localparam logic [3:0] VECT_BASE_DEF = 4'd8;

  localparam int PO_VALID  = 7;
  localparam int PO_PRI_HI = 6;
  localparam int PO_PRI_LO = 4;
  localparam int PO_VEC_HI = 3;
  localparam int PO_VEC_LO = 0;

  typedef enum logic {
    PIC_IDLE = 1'b0,
    PIC_ACK  = 1'b1
  } pic_state_e;

  function automatic logic [7:0] pic_word(
    input logic [2:0] p,
    input logic [3:0] v
  );
    logic [7:0] w;
    w = '0;
    w[PO_VALID] = 1'b1;
    w[PO_PRI_HI:PO_PRI_LO] = p;
    w[PO_VEC_HI:PO_VEC_LO] = v;
    return w;
  endfunction

endpackage

// File: rtl/pic_arbiter.sv
// xm23 PIC arbiter: highest priority pending+enabled source.
// Ties resolve to the lowest source index.
module pic_arbiter #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]      pending,
  input  logic [NSRC-1:0]      en,
  input  logic [NSRC-1:0][2:0] pri,
  output logic                 found,
  output logic [2:0]           index,
  output logic [2:0]           prio
);

  // Scan high-to-low so an equal priority at a lower index wins.
  always_comb begin
    found = 1'b0;
    index = 3'd0;
    prio  = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending[i] && en[i] && (!found || pri[i] >= prio)) begin
        found = 1'b1;
        index = 3'(i);
        prio  = pri[i];
      end
    end
  end

endmodule

// File: rtl/xm23_pic.sv
// xm23 programmable interrupt controller.
// Edge-latched sources, priority arbitration, CPU ack handshake.
module xm23_pic
  import xm23_pkg::*;
#(
  parameter int         NSRC      = 8,
  parameter logic [3:0] VECT_BASE = VECT_BASE_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [3:0]      cfg_data,
  input  logic [2:0]      cpu_pri,
  input  logic            pic_read,
  output logic            irq,
  output logic [7:0]      pic_out
);

  logic [NSRC-1:0]      src_q;
  logic [NSRC-1:0]      pending;
  logic [NSRC-1:0]      en;
  logic [NSRC-1:0][2:0] pri;
  logic [NSRC-1:0]      rise;
  logic [NSRC-1:0]      clr;

  pic_state_e state_q, state_n;

  logic       found;
  logic [2:0] win_idx;
  logic [2:0] win_pri;
  logic       irq_n;
  logic [7:0] out_n;

  assign rise = irq_src & ~src_q;

  pic_arbiter #(.NSRC(NSRC)) u_arb (
    .pending (pending),
    .en      (en),
    .pri     (pri),
    .found   (found),
    .index   (win_idx),
    .prio    (win_pri)
  );

  // Ack handshake next-state, pending clear and output staging.
  always_comb begin
    state_n = state_q;
    clr     = '0;
    out_n   = pic_out;
    unique case (state_q)
      PIC_IDLE: begin
        if (pic_read) begin
          if (irq && found) begin
            out_n   = pic_word(win_pri, 4'(VECT_BASE + {1'b0, win_idx}));
            clr     = NSRC'(1) << win_idx;
            state_n = PIC_ACK;
          end else begin
            out_n = 8'h00;
          end
        end
      end
      PIC_ACK: begin
        out_n   = 8'h00;
        state_n = PIC_IDLE;
      end
      default: begin
        out_n   = 8'h00;
        state_n = PIC_IDLE;
      end
    endcase
    irq_n = (state_n == PIC_IDLE) && found && (win_pri > cpu_pri);
  end

  // State, pending latches, configuration and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      src_q   <= irq_src;
      pending <= '0;
      en      <= '0;
      pri     <= '0;
      state_q <= PIC_IDLE;
      irq     <= 1'b0;
      pic_out <= 8'h00;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr) | rise;
      state_q <= state_n;
      irq     <= irq_n;
      pic_out <= out_n;
      if (cfg_we) begin
        for (int i = 0; i < NSRC; i++) begin
          if (cfg_addr == 3'(i)) begin
            en[i]  <= cfg_data[3];
            pri[i] <= cfg_data[2:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xm23_pic.sv
// Self-checking bench for xm23_pic.
// Expected ack words are queued at the strobe and popped after it.
module tb_xm23_pic;
  import xm23_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] irq_src;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_data;
  logic [2:0] cpu_pri;
  logic       pic_read;
  logic       irq;
  logic [7:0] pic_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;
  logic       ok;

  always #5 Clock = ~Clock;

  xm23_pic dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .irq_src  (irq_src),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cpu_pri  (cpu_pri),
    .pic_read (pic_read),
    .irq      (irq),
    .pic_out  (pic_out)
  );

  function automatic logic [7:0] model_word(int idx, logic [2:0] p);
    logic [3:0] v;
    v = 4'(8 + idx);
    return {1'b1, p, v};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic cfg(input int idx, input logic e, input logic [2:0] p);
    cfg_we   = 1'b1;
    cfg_addr = 3'(idx);
    cfg_data = {e, p};
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_ack();
    pic_read = 1'b1;
    tick();
    pic_read = 1'b0;
  endtask

  task automatic wait_irq(output logic got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (irq) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    irq_src = 8'h00; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    cpu_pri = 0; pic_read = 0;
    do_reset();
    checks++;
    if (irq !== 1'b0 || pic_out !== 8'h00 || dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL reset: irq=%b pic_out=%h pending=%h want 0/00/00",
               irq, pic_out, dut.pending);
    end
  endtask

  task automatic test_basic();
    do_reset();
    cfg(3, 1'b1, 3'd5);
    cpu_pri = 3'd2;
    irq_src = 8'h08;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL basic_lat1: irq=%b want 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL basic_lat2: irq=%b want 1", irq);
    end
    exp_q.push_back(model_word(3, 3'd5));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp || exp !== 8'hDB) begin
      errors++; $display("FAIL basic_out: pic_out=%h want %h", pic_out, exp);
    end
    checks++;
    if (irq !== 1'b0 || dut.pending[3] !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: irq=%b pend3=%b want 0/0", irq, dut.pending[3]);
    end
    tick();
    checks++;
    if (pic_out !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: pic_out=%h irq=%b want 00/0", pic_out, irq);
    end
    irq_src = 8'h00;
  endtask

  task automatic test_tie();
    do_reset();
    cfg(1, 1'b1, 3'd4);
    cfg(6, 1'b1, 3'd4);
    cpu_pri = 3'd0;
    irq_src = 8'h42;
    tick();
    wait_irq(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL tie_irq1: irq=%b want 1 (timeout)", irq);
    end
    exp_q.push_back(model_word(1, 3'd4));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp) begin
      errors++; $display("FAIL tie_first: pic_out=%h want %h", pic_out, exp);
    end
    tick();
    wait_irq(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL tie_irq2: irq=%b want 1 (timeout)", irq);
    end
    exp_q.push_back(model_word(6, 3'd4));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp) begin
      errors++; $display("FAIL tie_second: pic_out=%h want %h", pic_out, exp);
    end
    tick();
    tick();
    checks++;
    if (irq !== 1'b0 || dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL tie_drain: irq=%b pending=%h want 0/00", irq, dut.pending);
    end
    irq_src = 8'h00;
  endtask

  task automatic test_threshold();
    do_reset();
    cfg(2, 1'b1, 3'd3);
    cpu_pri = 3'd3;
    irq_src = 8'h04;
    tick(); tick(); tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL thr_equal: irq=%b want 0", irq);
    end
    cpu_pri = 3'd2;
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL thr_lower: irq=%b want 1", irq);
    end
    exp_q.push_back(model_word(2, 3'd3));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp) begin
      errors++; $display("FAIL thr_out: pic_out=%h want %h", pic_out, exp);
    end
    tick();
    irq_src = 8'h00;
  endtask

  task automatic test_spurious_disabled();
    do_reset();
    cpu_pri = 3'd0;
    irq_src = 8'h20;
    tick(); tick();
    checks++;
    if (irq !== 1'b0 || dut.pending[5] !== 1'b1) begin
      errors++;
      $display("FAIL dis_pend: irq=%b pend5=%b want 0/1", irq, dut.pending[5]);
    end
    exp_q.push_back(8'h00);
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp || dut.state_q !== PIC_IDLE) begin
      errors++;
      $display("FAIL spurious: pic_out=%h state=%0d want %h/IDLE",
               pic_out, dut.state_q, exp);
    end
    checks++;
    if (dut.pending[5] !== 1'b1) begin
      errors++; $display("FAIL dis_keep: pend5=%b want 1", dut.pending[5]);
    end
    cfg(5, 1'b1, 3'd1);
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL reenable: irq=%b want 1", irq);
    end
    exp_q.push_back(model_word(5, 3'd1));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp) begin
      errors++; $display("FAIL reen_out: pic_out=%h want %h", pic_out, exp);
    end
    tick();
    irq_src = 8'h00;
  endtask

  task automatic test_coincident();
    do_reset();
    cfg(0, 1'b1, 3'd7);
    cpu_pri = 3'd0;
    irq_src = 8'h01;
    tick(); tick();
    irq_src = 8'h00;
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL coin_irq: irq=%b want 1", irq);
    end
    irq_src = 8'h01;
    exp_q.push_back(model_word(0, 3'd7));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp || dut.pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL coin_ack: pic_out=%h pend0=%b want %h/1",
               pic_out, dut.pending[0], exp);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || pic_out !== 8'h00) begin
      errors++;
      $display("FAIL coin_reassert: irq=%b pic_out=%h want 1/00", irq, pic_out);
    end
    exp_q.push_back(model_word(0, 3'd7));
    do_ack();
    exp = exp_q.pop_front();
    checks++;
    if (pic_out !== exp) begin
      errors++; $display("FAIL coin_ack2: pic_out=%h want %h", pic_out, exp);
    end
    tick();
    irq_src = 8'h00;
  endtask

  task automatic test_reset_in_ack();
    do_reset();
    cfg(4, 1'b1, 3'd6);
    cpu_pri = 3'd0;
    irq_src = 8'h10;
    tick(); tick();
    do_ack();
    checks++;
    if (pic_out !== model_word(4, 3'd6)) begin
      errors++;
      $display("FAIL rst_pre: pic_out=%h want %h", pic_out, model_word(4, 3'd6));
    end
    irq_src = 8'hFF;
    do_reset();
    checks++;
    if (pic_out !== 8'h00 || irq !== 1'b0 || dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL rst_ack: pic_out=%h irq=%b pending=%h want 00/0/00",
               pic_out, irq, dut.pending);
    end
    tick(); tick();
    checks++;
    if (irq !== 1'b0 || dut.pending !== 8'h00) begin
      errors++;
      $display("FAIL rst_level: irq=%b pending=%h want 0/00", irq, dut.pending);
    end
    irq_src = 8'h00;
  endtask

  initial begin
    Reset = 1'b1;
    test_reset();
    test_basic();
    test_tie();
    test_threshold();
    test_spurious_disabled();
    test_coincident();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xm23_pic.md
XM23_PIC -- requirements
Module: xm23_pic

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources (1..8).
REQ-002 SHALL have parameter VECT_BASE, default 4'd8, meaning the vector number of source 0; source i maps to VECT_BASE+i, modulo 16.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port irq_src, input, NSRC bits: device interrupt request levels; an event is a rising edge.
REQ-006 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-007 SHALL have port cfg_addr, input, 3 bits: source index to configure.
REQ-008 SHALL have port cfg_data, input, 4 bits: {enable, priority[2:0]}.
REQ-009 SHALL have port cpu_pri, input, 3 bits: current CPU priority (PSW[7:5]).
REQ-010 SHALL have port pic_read, input, 1 bit: one-cycle acknowledge strobe from the CPU.
REQ-011 SHALL have port irq, output, 1 bit: interrupt request to the CPU.
REQ-012 SHALL have port pic_out, output, 8 bits: {valid, priority[2:0], vector[3:0]}, read by the CPU as pic_in.

Function
REQ-013 SHALL register irq_src each cycle and set pending[i] on a 0->1 transition of irq_src[i]; pending latches regardless of enable.
REQ-014 SHALL, on cfg_we with cfg_addr<NSRC, write en[cfg_addr] and pri[cfg_addr] at the next edge; cfg_addr>=NSRC is ignored.
REQ-015 SHALL select as winner the pending, enabled source with the highest pri; ties go to the lowest index.
REQ-016 SHALL assert irq (registered, one-cycle latency from pending or config change) iff a winner exists with pri > cpu_pri (strict) and the FSM is in IDLE.
REQ-017 SHALL implement FSM states IDLE and ACK.
REQ-018 SHALL, in IDLE with pic_read=1 and irq=1: load pic_out={1,pri_w,VECT_BASE+w}, clear pending[w], and go to ACK.
REQ-019 SHALL, in IDLE with pic_read=1 and irq=0 (spurious): load pic_out=8'h00 and stay in IDLE.
REQ-020 SHALL, in ACK: hold pic_out for exactly one cycle, keep irq=0, ignore pic_read, then return to IDLE and clear pic_out to 8'h00.
REQ-021 SHALL keep pending[w] set when a new rising edge on source w coincides with the acknowledge clearing it.
REQ-022 SHALL leave pending[i] untouched when source i is disabled; re-enabling it makes the source eligible again.
REQ-023 SHALL take the winner and priority from state registered before the pic_read edge; a cfg_we in the same cycle affects only later arbitration.

Reset
REQ-024 SHALL, on Reset=1 at a rising edge: clear pending, en and pri to 0; set the FSM to IDLE, irq=0 and pic_out=8'h00; load the edge-detect register from the current irq_src so that a level already high does not raise an event.
REQ-025 SHALL give Reset priority over cfg_we, pic_read and edge events in the same cycle; an acknowledge in progress is aborted.

Structure
REQ-026 SHALL place the FSM state encoding, the pic_out field positions and the default VECT_BASE in the shared xm23 package.
REQ-027 SHALL implement arbitration as one combinational sub-module, pic_arbiter (inputs: pending, en, pri; outputs: found, index, priority).

Verification
REQ-028 Scenario: src3 pri=5 en=1, cpu_pri=2, edge on src3 -> irq=1 two cycles later; pic_read -> pic_out=8'hDB next cycle; irq=0; pending[3] cleared.
REQ-029 Scenario: src1 and src6 both pri=4 and pending, cpu_pri=0 -> acknowledge returns vector 9; a second acknowledge returns vector 14.
REQ-030 Scenario: src2 pri=3, cpu_pri=3 -> irq stays 0; set cpu_pri=2 -> irq=1 within one cycle.
REQ-031 Scenario: pic_read with nothing pending -> pic_out=8'h00, FSM remains in IDLE.
REQ-032 Scenario: edge on src0 in the same cycle that src0 is acknowledged -> pending[0] stays 1, and irq reasserts after ACK.
REQ-033 Scenario: Reset asserted during ACK with irq_src=8'hFF held high -> pic_out=8'h00, no pending bits, and irq=0 after Reset is released.
